// File: rtl/mem_pkg.sv
// Shared encodings for the memory arbiter: access sizes, FSM states and default depth.
package mem_pkg;

   localparam int MEM_WORDS_DEF = 64;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-control bundle between the two requesters, the arbiter and the memory.
interface mem_arbiter_if;

   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic        d_unsigned;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;

   logic        mem_cs;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
      output mem_cs, mem_we, mem_addr
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
      input  mem_cs, mem_we, mem_addr
   );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store mask/replication, load extract/extend, misalign detect.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_fetch,
   input  logic        i_unsigned,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rbus,
   output logic [3:0]  o_wmask,
   output logic [31:0] o_wbus,
   output logic [31:0] o_rdata,
   output logic        o_misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rbus[{i_addr_lo, 3'b000} +: 8];
   assign w_half = i_addr_lo[1] ? i_rbus[31:16] : i_rbus[15:0];

   always_comb begin
      o_wmask    = 4'b0000;
      o_wbus     = i_wdata;
      o_rdata    = i_rbus;
      o_misalign = 1'b0;
      if (i_fetch) begin
         o_misalign = |i_addr_lo;
      end else begin
         case (i_size)
            SZ_B: begin
               o_wmask = 4'b0001 << i_addr_lo;
               o_wbus  = {4{i_wdata[7:0]}};
               o_rdata = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SZ_H: begin
               o_misalign = i_addr_lo[0];
               o_wmask    = 4'b0011 << i_addr_lo;
               o_wbus     = {2{i_wdata[15:0]}};
               o_rdata    = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            // size 3 is treated as a word access
            default: begin
               o_misalign = |i_addr_lo;
               o_wmask    = 4'b1111;
            end
         endcase
      end
      if (o_misalign) begin
         o_wmask = 4'b0000;
         o_rdata = 32'b0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-ported word memory with a shared tristate bus.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
//
// state     | meaning
// ST_IDLE   | grants issued combinationally, payload latched on the granting edge
// ST_ACCESS | memory cycle for the latched request; response registered at its end
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   mem_arbiter_if.slave bus,
   inout  wire  [31:0] mem_bus
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_i_gnt;
   logic        w_d_gnt;
   logic        w_prio_d;

   logic        r_port_d;
   logic        r_we;
   logic [1:0]  r_size;
   logic        r_uns;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;

   logic        r_i_rvalid;
   logic        r_d_rvalid;
   logic        r_d_err;
   logic [31:0] r_i_rdata;
   logic [31:0] r_d_rdata;

   logic        w_access;
   logic        w_store;
   logic [29:0] w_word;
   logic [3:0]  w_wmask;
   logic [31:0] w_wbus;
   logic [31:0] w_rdata;
   logic        w_misalign;

`ifdef MEM_ARB_RR_EN
   logic r_prio_d;

   // Priority flips to whichever port was not served by the latest grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prio_d <= 1'b1;
      end else if (w_i_gnt || w_d_gnt) begin
         r_prio_d <= w_i_gnt;
      end
   end

   assign w_prio_d = r_prio_d;
`else
   assign w_prio_d = 1'b1;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_i_gnt     = 1'b0;
      w_d_gnt     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_d_gnt = !rst && bus.d_req && (w_prio_d || !bus.i_req);
            w_i_gnt = !rst && bus.i_req && !w_d_gnt;
            if (w_i_gnt || w_d_gnt) begin
               w_state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_port_d <= 1'b1;
         r_we     <= 1'b0;
         r_size   <= SZ_W;
         r_uns    <= 1'b0;
         r_addr   <= 32'b0;
         r_wdata  <= 32'b0;
      end else if (w_d_gnt) begin
         r_port_d <= 1'b1;
         r_we     <= bus.d_we;
         r_size   <= bus.d_size;
         r_uns    <= bus.d_unsigned;
         r_addr   <= bus.d_addr;
         r_wdata  <= bus.d_wdata;
      end else if (w_i_gnt) begin
         r_port_d <= 1'b0;
         r_we     <= 1'b0;
         r_size   <= SZ_W;
         r_uns    <= 1'b0;
         r_addr   <= bus.i_addr;
      end
   end

   mem_lane_align u_align (
      .i_size     (r_size),
      .i_addr_lo  (r_addr[1:0]),
      .i_fetch    (!r_port_d),
      .i_unsigned (r_uns),
      .i_wdata    (r_wdata),
      .i_rbus     (mem_bus),
      .o_wmask    (w_wmask),
      .o_wbus     (w_wbus),
      .o_rdata    (w_rdata),
      .o_misalign (w_misalign)
   );

   // Load data is captured from the bus on the edge that ends ACCESS.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_i_rvalid <= 1'b0;
         r_d_rvalid <= 1'b0;
         r_d_err    <= 1'b0;
         r_i_rdata  <= 32'b0;
         r_d_rdata  <= 32'b0;
      end else begin
         r_i_rvalid <= 1'b0;
         r_d_rvalid <= 1'b0;
         r_d_err    <= 1'b0;
         if (w_access) begin
            if (r_port_d) begin
               r_d_rvalid <= 1'b1;
               r_d_err    <= w_misalign;
               r_d_rdata  <= r_we ? 32'b0 : w_rdata;
            end else begin
               r_i_rvalid <= 1'b1;
               r_i_rdata  <= w_rdata;
            end
         end
      end
   end

   assign w_access = (r_state == ST_ACCESS);
   assign w_store  = w_access && r_port_d && r_we && !w_misalign;
   assign w_word   = r_addr[31:2] % 30'(MEM_WORDS);

   assign bus.i_gnt    = w_i_gnt;
   assign bus.d_gnt    = w_d_gnt;
   assign bus.i_rvalid = r_i_rvalid;
   assign bus.i_rdata  = r_i_rdata;
   assign bus.d_rvalid = r_d_rvalid;
   assign bus.d_rdata  = r_d_rdata;
   assign bus.d_err    = r_d_err;

   assign bus.mem_cs   = w_access && !w_misalign;
   assign bus.mem_we   = w_store ? w_wmask : 4'b0000;
   assign bus.mem_addr = w_access ? {2'b00, w_word} : 32'b0;
   assign mem_bus      = w_store ? w_wbus : 32'bz;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus randomized traffic against a byte-image model.
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int MW = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if bus ();
   wire [31:0] mem_bus;

   mem_arbiter #(.MEM_WORDS(MW)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .mem_bus (mem_bus)
   );

   // memory device attached to the bus
   logic [31:0] dev [MW];
   logic        clr_dev;
   logic        w_tb_oe;
   logic [5:0]  w_idx;
   logic [31:0] w_tb_val;

   assign w_idx    = bus.mem_addr[5:0];
   assign w_tb_oe  = !(bus.mem_cs && (bus.mem_we != 4'b0000));
   assign w_tb_val = bus.mem_cs ? dev[w_idx] : 32'h0;
   assign mem_bus  = w_tb_oe ? w_tb_val : 32'bz;

   always @(posedge clk) begin
      if (clr_dev) begin
         for (int i = 0; i < MW; i++) dev[i] <= 32'h0;
      end else if (bus.mem_cs) begin
         for (int b = 0; b < 4; b++)
            if (bus.mem_we[b]) dev[w_idx][8*b +: 8] <= mem_bus[8*b +: 8];
      end
   end

   // reference model: flat byte image of the memory
   logic [7:0] rb [4*MW];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % MW);
   endfunction

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : 4;
   endfunction

   function automatic bit misal(input bit fetch, input logic [1:0] sz, input logic [1:0] lo);
      if (fetch || nbytes(sz) == 4) return lo != 2'b00;
      if (nbytes(sz) == 2) return lo[0];
      return 1'b0;
   endfunction

   function automatic logic [3:0] exp_mask(input logic [1:0] sz, input logic [1:0] lo);
      logic [3:0] m = 4'b0000;
      for (int k = 0; k < nbytes(sz); k++)
         if (int'(lo) + k < 4) m[int'(lo) + k] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
      int n = nbytes(sz);
      int base = widx(a) * 4 + int'(a[1:0]);
      logic [31:0] v = 32'h0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = rb[base + k];
      if (!uns && n < 4 && v[8*n - 1])
         for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
      return v;
   endfunction

   task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      int base = widx(a) * 4 + int'(a[1:0]);
      for (int k = 0; k < nbytes(sz); k++) rb[base + k] = wd[8*k +: 8];
   endtask

   task automatic data_op(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
      bit          mis;
      logic [3:0]  em;
      logic [31:0] exp_rd;
      int          waitc;
      mis    = misal(1'b0, sz, a[1:0]);
      em     = (mis || !we) ? 4'b0000 : exp_mask(sz, a[1:0]);
      exp_rd = (we || mis) ? 32'h0 : ref_load(sz, uns, a);
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = we; bus.d_size = sz; bus.d_unsigned = uns;
      bus.d_addr = a; bus.d_wdata = wd;
      #1;
      waitc = 0;
      while (!bus.d_gnt && waitc < 8) begin @(negedge clk); #1; waitc++; end
      chk({tag, " d_gnt"}, 32'(bus.d_gnt), 32'd1);
      if (!bus.d_gnt) begin bus.d_req = 1'b0; return; end
      @(posedge clk); #1 bus.d_req = 1'b0;
      @(negedge clk);
      chk({tag, " mem_cs"}, 32'(bus.mem_cs), 32'(!mis));
      chk({tag, " mem_we"}, 32'(bus.mem_we), 32'(em));
      if (!mis) chk({tag, " mem_addr"}, bus.mem_addr, 32'(widx(a)));
      chk({tag, " d_gnt low"}, 32'(bus.d_gnt), 32'd0);
      if (we && !mis) ref_store(sz, a, wd);
      @(negedge clk);
      chk({tag, " d_rvalid"}, 32'(bus.d_rvalid), 32'd1);
      chk({tag, " d_rdata"}, bus.d_rdata, exp_rd);
      chk({tag, " d_err"}, 32'(bus.d_err), 32'(mis));
      @(negedge clk);
      chk({tag, " d_rvalid pulse"}, 32'(bus.d_rvalid), 32'd0);
      chk({tag, " d_rdata hold"}, bus.d_rdata, exp_rd);
   endtask

   task automatic fetch_op(input logic [31:0] a, input string tag);
      bit          mis;
      logic [31:0] exp_rd;
      int          waitc;
      mis    = misal(1'b1, SZ_W, a[1:0]);
      exp_rd = mis ? 32'h0 : ref_load(SZ_W, 1'b1, a);
      @(negedge clk);
      bus.i_req = 1'b1; bus.i_addr = a;
      #1;
      waitc = 0;
      while (!bus.i_gnt && waitc < 8) begin @(negedge clk); #1; waitc++; end
      chk({tag, " i_gnt"}, 32'(bus.i_gnt), 32'd1);
      if (!bus.i_gnt) begin bus.i_req = 1'b0; return; end
      @(posedge clk); #1 bus.i_req = 1'b0;
      @(negedge clk);
      chk({tag, " mem_cs"}, 32'(bus.mem_cs), 32'(!mis));
      chk({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
      @(negedge clk);
      chk({tag, " i_rvalid"}, 32'(bus.i_rvalid), 32'd1);
      chk({tag, " i_rdata"}, bus.i_rdata, exp_rd);
      @(negedge clk);
      chk({tag, " i_rvalid pulse"}, 32'(bus.i_rvalid), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      byte unsigned seq [$];
      byte unsigned exp_seq [3];
      int waitc;
      logic [31:0] a;
      logic [1:0]  sz;

      rst = 1'b1; clr_dev = 1'b1;
      bus.i_req = 1'b0; bus.i_addr = 32'h0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = SZ_W; bus.d_unsigned = 1'b0;
      bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
      for (int i = 0; i < 4*MW; i++) rb[i] = 8'h00;

      // reset state, with both requests asserted during reset
      @(negedge clk); @(negedge clk);
      bus.i_req = 1'b1; bus.d_req = 1'b1;
      #1;
      chk("rst i_gnt", 32'(bus.i_gnt), 32'd0);
      chk("rst d_gnt", 32'(bus.d_gnt), 32'd0);
      chk("rst mem_cs", 32'(bus.mem_cs), 32'd0);
      chk("rst mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst mem_addr", bus.mem_addr, 32'd0);
      chk("rst d_rvalid", 32'(bus.d_rvalid), 32'd0);
      chk("rst i_rvalid", 32'(bus.i_rvalid), 32'd0);
      chk("rst d_err", 32'(bus.d_err), 32'd0);
      chk("rst d_rdata", bus.d_rdata, 32'd0);
      chk("rst i_rdata", bus.i_rdata, 32'd0);
      chk("rst mem_bus", mem_bus, 32'd0);
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      @(negedge clk);
      rst = 1'b0; clr_dev = 1'b0;

      // word store then load
      data_op(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, "w_st");
      data_op(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, "w_ld");
      fetch_op(32'h10, "fetch");

      // byte store over a zero word, signed/unsigned loads
      data_op(1'b1, SZ_W, 1'b0, 32'h10, 32'h0, "zero_st");
      data_op(1'b1, SZ_B, 1'b0, 32'h13, 32'h00000080, "b_st");
      data_op(1'b0, SZ_B, 1'b0, 32'h13, 32'h0, "b_ld_s");
      data_op(1'b0, SZ_B, 1'b1, 32'h13, 32'h0, "b_ld_u");
      data_op(1'b0, SZ_H, 1'b0, 32'h12, 32'h0, "h_ld_s");

      // misaligned accesses
      data_op(1'b0, SZ_H, 1'b0, 32'h21, 32'h0, "h_mis");
      data_op(1'b1, SZ_W, 1'b0, 32'h22, 32'h5A5A5A5A, "w_st_mis");
      fetch_op(32'h102, "fetch_mis");

      // address wrap and size 3
      data_op(1'b1, 2'd3, 1'b0, 32'h0, 32'hCAFEF00D, "sz3_st");
      data_op(1'b0, SZ_W, 1'b0, 32'(4*MW), 32'h0, "wrap_ld");

      // arbitration with both ports requesting, starting from reset priority
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      bus.i_req = 1'b1; bus.i_addr = 32'h20;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = SZ_W; bus.d_addr = 32'h24;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk("arb exclusive", 32'(bus.i_gnt && bus.d_gnt), 32'd0);
         if (bus.d_gnt) seq.push_back(8'h44);
         else if (bus.i_gnt) seq.push_back(8'h49);
         @(negedge clk);
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      @(negedge clk); @(negedge clk); @(negedge clk);
`ifdef MEM_ARB_RR_EN
      exp_seq = '{8'h44, 8'h49, 8'h44};
`else
      exp_seq = '{8'h44, 8'h44, 8'h44};
`endif
      chk("arb count", 32'(seq.size()), 32'd3);
      for (int k = 0; k < 3; k++)
         chk("arb order", (k < seq.size()) ? 32'(seq[k]) : 32'h0, 32'(exp_seq[k]));

      // reset in the middle of a store
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = SZ_W; bus.d_unsigned = 1'b0;
      bus.d_addr = 32'h40; bus.d_wdata = 32'h12345678;
      #1;
      waitc = 0;
      while (!bus.d_gnt && waitc < 8) begin @(negedge clk); #1; waitc++; end
      chk("rst_mid d_gnt", 32'(bus.d_gnt), 32'd1);
      @(posedge clk); #1 bus.d_req = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_mid mem_cs", 32'(bus.mem_cs), 32'd0);
      chk("rst_mid mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mid mem_bus", mem_bus, 32'd0);
      @(negedge clk);
      chk("rst_mid d_rvalid", 32'(bus.d_rvalid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid d_rvalid after", 32'(bus.d_rvalid), 32'd0);
      data_op(1'b1, SZ_W, 1'b0, 32'h40, 32'h0BADF00D, "post_rst_st");
      data_op(1'b0, SZ_W, 1'b0, 32'h40, 32'h0, "post_rst_ld");

      // randomized traffic against the byte-image model
      for (int n = 0; n < 80; n++) begin
         a = 32'($urandom_range(0, 8*MW - 1));
         if ($urandom_range(0, 9) < 2) begin
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            fetch_op(a, "rnd_fetch");
         end else begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
               if (nbytes(sz) == 4) a[1:0] = 2'b00;
               else if (nbytes(sz) == 2) a[0] = 1'b0;
            end
            data_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, "rnd_data");
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, 64: word depth of attached Memory; mem_addr SHALL wrap modulo MEM_WORDS.
REQ-002 CLK  in  1  sole clock, all state on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 i_req / i_addr  in  1 / 32  instruction-fetch word read request, byte address.
REQ-005 i_gnt / i_rvalid / i_rdata  out  1 / 1 / 32  fetch grant, response valid, read word.
REQ-006 d_req / d_we / d_size / d_unsigned  in  1 / 1 / 2 / 1  data request, store, size (0=B, 1=H, 2=W), zero-extend load.
REQ-007 d_addr / d_wdata  in  32 / 32  data byte address, store data (LSB-justified).
REQ-008 d_gnt / d_rvalid / d_rdata / d_err  out  1 / 1 / 32 / 1  data grant, response valid, extended load data, misalign error.
REQ-009 mem_cs / mem_we / mem_addr  out  1 / 4 / 32  Memory chip select, byte-lane write enables, word index.
REQ-010 mem_bus  inout  32  shared Memory data bus.

Function
REQ-011 FSM SHALL have states IDLE and ACCESS; IDLE->ACCESS on any grant; ACCESS->IDLE unconditionally.
REQ-012 Grant SHALL be combinational in IDLE only, at most one of i_gnt/d_gnt high; both low in ACCESS.
REQ-013 Requester SHALL hold req and payload until its gnt; payload latched on the granting edge.
REQ-014 ACCESS: mem_cs=1, mem_addr=latched_addr[31:2] mod MEM_WORDS, mem_we=lane mask for stores else 4'b0000.
REQ-015 mem_bus SHALL be driven with lane-shifted store data only in ACCESS with a store; otherwise high-Z.
REQ-016 Store lanes: B -> 1<<addr[1:0], data replicated per byte; H -> 4'b0011<<addr[1:0]; W -> 4'b1111.
REQ-017 Loads: mem_bus sampled at the rising edge ending ACCESS; byte/halfword selected by addr[1:0], sign-extended unless d_unsigned.
REQ-018 rvalid of the served port SHALL pulse exactly one cycle, the cycle after ACCESS (stores too, rdata=0); latency req-granted to rvalid = 2 cycles; peak throughput one access per 2 cycles.
REQ-019 Misaligned (H with addr[0]=1, W with addr[1:0]!=0, any fetch with addr[1:0]!=0): ACCESS with mem_cs=0, mem_we=0; rvalid+d_err pulse together (i-port: i_rvalid, i_rdata=0).
REQ-020 d_size=3 SHALL be treated as W.
REQ-021 rdata SHALL hold its value until the next rvalid of that port.

Reset
REQ-022 RST high SHALL immediately force IDLE, mem_cs=0, mem_we=0, mem_addr=0, mem_bus=Z, all gnt/rvalid/d_err=0, rdata=0, priority pointer to data port.
REQ-023 Reset during ACCESS SHALL abort the transaction with no rvalid; a store write may or may not have occurred.

Configuration
REQ-024 Macro MEM_ARB_RR_EN defined: round-robin, the port not granted last wins when both request.
REQ-025 MEM_ARB_RR_EN undefined: fixed priority, data port always wins; pointer logic absent.

Structure
REQ-026 Package mem_pkg SHALL hold size encodings (SZ_B, SZ_H, SZ_W), FSM state enum and MEM_WORDS default.
REQ-027 Sub-module mem_lane_align SHALL implement store mask/shift, load extract/extend and misalign detect, purely combinational.

Verification
REQ-028 Word store d_addr=0x10, d_wdata=0xDEADBEEF, then word load 0x10 -> mem_we=4'b1111 at index 4; d_rdata=0xDEADBEEF, d_rvalid 2 cycles after grant.
REQ-029 Byte store 0x80 to 0x13 over 0x00000000, then signed B load 0x13 -> mem_we=4'b1000; d_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-030 i_req and d_req held high 6 cycles with MEM_ARB_RR_EN -> grants alternate D,I,D; without macro -> D,D,D, i_gnt never.
REQ-031 Halfword load at 0x21 -> mem_cs stays 0, d_rvalid and d_err pulse together, d_rdata=0.
REQ-032 RST asserted mid-ACCESS of store -> same cycle mem_cs=0, mem_bus=Z, no d_rvalid; next request granted after RST release.
REQ-033 Word load at address 4*MEM_WORDS -> mem_addr=0, returns word 0.
